fir_decimator: RTL and testbench
================================

Name: fir_decimator

Overview:
- Downstream consumer of the 3-tap FIR stage: takes the FIR's 8-bit output sample stream and block-averages every 2^LOG2_DEC samples into one result.
- Results are buffered in a small first-word-fall-through FIFO and presented on a valid/ready output port to the next stage.
- Sits between the FIR filter and any back-pressuring sink (serializer, memory writer).

Parameters:
- DW, 8, input and output sample width (matches FIR y width)
- LOG2_DEC, 2, log2 of decimation factor; DEC = 2^LOG2_DEC; legal 0..4
- ADDRW, 2, FIFO address width; DEPTH = 2^ADDRW entries

Ports:
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_data  input  DW  FIR output sample, unsigned
- in_valid  input  1  in_data is a new sample this cycle
- out_data  output  DW  FIFO head (averaged result)
- out_valid  output  1  FIFO not empty
- out_ready  input  1  sink accepts out_data this cycle
- count  output  ADDRW+1  current FIFO occupancy, 0..DEPTH
- overflow  output  1  sticky: a result was dropped because the FIFO was full
- clr_ovf  input  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, any time): acc=0, phase=0, FIFO pointers=0, count=0, out_valid=0, out_data=0, overflow=0. A partial block in progress is discarded.
- Accumulator: DW+LOG2_DEC bits, unsigned; it cannot overflow. phase counter: 0..DEC-1.
- in_valid=1 and phase<DEC-1: acc <= acc+in_data; phase++.
- in_valid=1 and phase==DEC-1: sum = acc+in_data; result = sum >> LOG2_DEC (truncation); push result; acc <= 0; phase <= 0.
- in_valid=0: acc and phase hold; gaps in the input are allowed.
- LOG2_DEC=0: every valid sample is pushed unchanged.
- Latency: result is written at the clock edge that accepts the DEC-th sample. out_valid is high the cycle after that edge when the FIFO was empty.
- FIFO:
  - First-word fall-through. out_data shows the head entry whenever out_valid=1; out_data is don't-care when out_valid=0.
  - pop = out_valid & out_ready. push = the block-complete event.
- Push and pop together when not empty: both occur, count unchanged.
- Push when full without pop: result dropped, FIFO unchanged, overflow <= 1.
- Push when full with pop: both occur; no overflow.
- Pop when empty: impossible by definition (out_valid=0); out_ready is ignored.
- Pointers wrap modulo DEPTH. count = number of entries, DEPTH when full.
- overflow: sticky until clr_ovf=1. If clr_ovf coincides with a new drop, set wins (overflow stays 1).
- out_data, out_valid, count and overflow are registered or derived only from registers; no combinational path from in_* to out_*.

Optional Feature:
- Macro FIR_DECIMATOR_ROUND_EN.
- Defined: sum plus 2^(LOG2_DEC-1) is shifted (round half up); no rounding term when LOG2_DEC=0. The maximum rounded value still fits DW bits, so no saturation is needed.
- Undefined: plain truncation as in Behaviour.

Test Plan:
- Reset, then in_valid=1 with 10,20,30,40, out_ready=1 (LOG2_DEC=2): one result 25, out_valid high for exactly 1 cycle, the cycle after the 4th sample; count returns to 0.
- Samples 1,2,2,2: truncation build gives out_data=1; FIR_DECIMATOR_ROUND_EN build gives out_data=2. Samples 255x4 give 255 in both builds.
- out_ready=0 while pushing 5 blocks of 8,8,8,8: count=4 after the 4th block; overflow=1 after the 5th. Then out_ready=1 drains exactly four 8s.
- With the FIFO full, the 5th block completes in the same cycle as a pop: overflow stays 0, count stays 4. Then clr_ovf=1 with a concurrent drop leaves overflow=1.
- Samples 5,_,6,_,7,_,8 with in_valid toggling 1/0: one result 6 (26>>2), phase unaffected by gaps.
- Feed 3 samples, assert reset for 1 cycle, then feed 4,4,4,4: single result 4. Prior partial data is discarded; all outputs are 0 during reset.

Source files
------------

// File: rtl/fir_decimator.sv
// Block-average decimator with a first-word-fall-through result FIFO.
// Define FIR_DECIMATOR_ROUND_EN to round half up instead of truncating.
module fir_decimator #(
  parameter int DW       = 8,
  parameter int LOG2_DEC = 2,
  parameter int ADDRW    = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [DW-1:0]  in_data,
  input  logic           in_valid,
  output logic [DW-1:0]  out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [ADDRW:0] count,
  output logic           overflow,
  input  logic           clr_ovf
);

  localparam int DEC   = 1 << LOG2_DEC;
  localparam int DEPTH = 1 << ADDRW;
  localparam int AW    = DW + LOG2_DEC;
  localparam int PW    = (LOG2_DEC > 0) ? LOG2_DEC : 1;

  localparam logic [PW-1:0]  LAST = PW'(DEC - 1);
  localparam logic [ADDRW:0] FULL = (ADDRW + 1)'(DEPTH);

`ifdef FIR_DECIMATOR_ROUND_EN
  localparam logic [AW-1:0] RND = AW'(DEC / 2);
`else
  localparam logic [AW-1:0] RND = '0;
`endif

  logic [AW-1:0]    acc;
  logic [AW-1:0]    sum;
  logic [PW-1:0]    phase;
  logic [DW-1:0]    result;
  logic [DW-1:0]    mem [DEPTH];
  logic [ADDRW-1:0] wptr;
  logic [ADDRW-1:0] rptr;
  logic [ADDRW:0]   cnt;
  logic             done;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  // Sum of DEC samples fits AW bits, rounding term included
  assign sum    = acc + AW'(in_data);
  assign result = DW'((sum + RND) >> LOG2_DEC);

  assign done = in_valid & (phase == LAST);
  assign full = (cnt == FULL);
  assign pop  = out_valid & out_ready;
  assign push = done & (~full | pop);
  assign drop = done & full & ~pop;

  assign out_valid = (cnt != '0);
  assign out_data  = out_valid ? mem[rptr] : '0;
  assign count     = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      phase <= '0;
    end else if (in_valid) begin
      if (phase == LAST) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= sum;
        phase <= phase + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= result;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
      // A drop in the same cycle as a clear keeps the flag set
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// Scoreboard bench for fir_decimator: block-average model feeds an
// expected-result queue; a negedge monitor checks every output cycle.
module tb_fir_decimator;

  localparam int DW    = 8;
  localparam int L     = 2;
  localparam int AWF   = 2;
  localparam int DEC   = 1 << L;
  localparam int DEPTH = 1 << AWF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AWF:0]  count;
  logic          overflow;
  logic          clr_ovf = 1'b0;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int blk[$];
  bit mov = 1'b0;
  bit p_v = 1'b0;
  bit p_clr = 1'b0;
  bit p_rst = 1'b1;
  int p_d = 0;

  fir_decimator #(
    .DW(DW),
    .LOG2_DEC(L),
    .ADDRW(AWF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count(count),
    .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Effect of the edge just taken, from the inputs applied before it
  task automatic model_edge();
    int  s;
    bit  drop;
    drop = 1'b0;
    if (p_v) begin
      blk.push_back(p_d);
      if (blk.size() == DEC) begin
        s = 0;
        foreach (blk[i]) s += blk[i];
`ifdef FIR_DECIMATOR_ROUND_EN
        s += DEC / 2;
`endif
        blk.delete();
        if (exp_q.size() < DEPTH)
          exp_q.push_back(s / DEC);
        else
          drop = 1'b1;
      end
    end
    if (drop)
      mov = 1'b1;
    else if (p_clr)
      mov = 1'b0;
  endtask

  task automatic cyc(bit v, int d, bit r, bit c, bit rs = 1'b0);
    @(posedge clk);
    #1;
    if (!p_rst)
      model_edge();
    reset     = rs;
    in_valid  = v;
    in_data   = DW'(d);
    out_ready = r;
    clr_ovf   = c;
    if (rs) begin
      blk.delete();
      exp_q.delete();
      mov = 1'b0;
    end
    p_v   = v;
    p_d   = d;
    p_clr = c;
    p_rst = rs;
  endtask

  task automatic block(int a, int b, int c, int d, bit r);
    cyc(1, a, r, 0);
    cyc(1, b, r, 0);
    cyc(1, c, r, 0);
    cyc(1, d, r, 0);
  endtask

  task automatic idle(int n, bit r);
    for (int i = 0; i < n; i++) cyc(0, 0, r, 0);
  endtask

  always @(negedge clk) begin
    check("count", 32'(count), 32'(exp_q.size()));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    check("overflow", 32'(overflow), 32'(mov));
    if (reset)
      check("out_data_in_reset", 32'(out_data), 32'd0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got %0d expected none", out_data);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    idle(2, 1);

    block(10, 20, 30, 40, 1);
    idle(3, 1);

    block(1, 2, 2, 2, 1);
    block(255, 255, 255, 255, 1);
    idle(3, 1);

    for (int b = 0; b < 5; b++) block(8, 8, 8, 8, 0);
    idle(3, 0);
    idle(6, 1);
    cyc(0, 0, 1, 1);

    for (int b = 0; b < 4; b++) block(8, 8, 8, 8, 0);
    cyc(1, 9, 0, 0);
    cyc(1, 9, 0, 0);
    cyc(1, 9, 0, 0);
    cyc(1, 9, 1, 0);
    idle(2, 0);
    block(3, 3, 3, 3, 0);
    cyc(1, 7, 0, 0);
    cyc(1, 7, 0, 0);
    cyc(1, 7, 0, 0);
    cyc(1, 7, 0, 1);
    idle(2, 0);
    idle(6, 1);
    cyc(0, 0, 1, 1);

    cyc(1, 5, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 6, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 7, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 8, 1, 0);
    idle(3, 1);

    cyc(1, 100, 1, 0);
    cyc(1, 100, 1, 0);
    cyc(1, 100, 1, 0);
    cyc(0, 0, 1, 0, 1);
    block(4, 4, 4, 4, 1);
    idle(3, 1);

    for (int i = 0; i < 600; i++)
      cyc(($urandom % 4) != 0, $urandom_range(0, 255),
          ($urandom % 3) == 0, ($urandom % 16) == 0);
    idle(10, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
